// File: rtl/ebpf_alu_pkg.sv
// ebpf_alu_pkg: shared types and helpers for the eBPF ALU units.
package ebpf_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALU32_WIDTH     = 32;
    localparam int ALU32_MASK_BITS = 5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ebpf_shift_step.sv
// ebpf_shift_step: one combinational shift step of up to STEP bits with eBPF fill rules.
module ebpf_shift_step
    import ebpf_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STEP       = 4,
    localparam int NW        = clog2(STEP) + 1
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [NW-1:0]         n,
    input  logic                  left,
    input  logic                  arith,
    input  logic                  sign,
    input  logic                  alu32,
    output logic [DATA_WIDTH-1:0] res
);

    localparam logic [DATA_WIDTH-1:0] LO_MASK = DATA_WIDTH'({ALU32_WIDTH{1'b1}});

    logic [DATA_WIDTH-1:0] m;

    // In ALU32 the window is the low 32 bits: fill enters at bit 31 and nothing escapes above it.
    assign m   = alu32 ? LO_MASK : '1;
    assign res = left ? (acc << n) & m
                      : (acc >> n) | ({DATA_WIDTH{arith & sign}} & m & ~(m >> n));

endmodule

// File: rtl/ebpf_shift_unit.sv
// ebpf_shift_unit: multi-cycle eBPF LSH/RSH/ARSH unit shifting up to STEP bits per cycle.
module ebpf_shift_unit
    import ebpf_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STEP       = 4,
    parameter bit HAS_ALU32  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stb,
    input  logic                  left,
    input  logic                  arith,
    input  logic                  alu32,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [DATA_WIDTH-1:0] shift,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ack,
    output logic                  busy
);

    localparam int AW   = clog2(DATA_WIDTH);
    localparam int RW   = AW + 1;
    localparam int NW   = clog2(STEP) + 1;
    localparam bit EN32 = HAS_ALU32 && (DATA_WIDTH == 64);
    localparam int SB32 = EN32 ? ALU32_WIDTH - 1 : DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] LO_MASK = DATA_WIDTH'({ALU32_WIDTH{1'b1}});

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_in;
    logic [DATA_WIDTH-1:0] stepped;
    logic [RW-1:0]         rem;
    logic [RW-1:0]         amt;
    logic [NW-1:0]         n;
    logic                  left_q;
    logic                  arith_q;
    logic                  sign_q;
    logic                  alu32_q;
    logic                  use32;
    logic                  unused_bits;

    assign use32       = EN32 & alu32;
    assign amt         = use32 ? RW'(shift[ALU32_MASK_BITS-1:0]) : RW'(shift[AW-1:0]);
    assign acc_in      = use32 ? value & LO_MASK : value;
    assign n           = (rem > RW'(STEP)) ? NW'(STEP) : NW'(rem);
    assign busy        = state != IDLE;
    assign unused_bits = ^{shift, alu32};

    ebpf_shift_step #(
        .DATA_WIDTH(DATA_WIDTH),
        .STEP      (STEP)
    ) u_step (
        .acc  (acc),
        .n    (n),
        .left (left_q),
        .arith(arith_q),
        .sign (sign_q),
        .alu32(alu32_q),
        .res  (stepped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            rem     <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
            alu32_q <= 1'b0;
            out     <= '0;
            ack     <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (state == IDLE) begin
                if (stb) begin
                    acc     <= acc_in;
                    rem     <= amt;
                    left_q  <= left;
                    arith_q <= arith;
                    sign_q  <= use32 ? value[SB32] : value[DATA_WIDTH-1];
                    alu32_q <= use32;
                    state   <= RUN;
                end
            end else if (state == RUN) begin
                if (rem == '0) begin
                    out   <= acc;
                    ack   <= 1'b1;
                    state <= DONE;
                end else begin
                    acc <= stepped;
                    rem <= rem - RW'(n);
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ebpf_shift_unit.sv
// tb_ebpf_shift_unit: vector table, random ops against an arithmetic model, and handshake corner cases.
`timescale 1ns/1ps
module tb_ebpf_shift_unit;

    localparam int DW   = 64;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0;
    logic          left = 1'b0;
    logic          arith = 1'b0;
    logic          alu32 = 1'b0;
    logic [DW-1:0] value = '0;
    logic [DW-1:0] shift = '0;
    logic [DW-1:0] out;
    logic          ack;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] v;
        logic [63:0] s;
        logic        l;
        logic        a;
        logic        a32;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    ebpf_shift_unit #(.DATA_WIDTH(DW), .STEP(STEP), .HAS_ALU32(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .stb  (stb),
        .left (left),
        .arith(arith),
        .alu32(alu32),
        .value(value),
        .shift(shift),
        .out  (out),
        .ack  (ack),
        .busy (busy)
    );

    always #1 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] v, input logic [63:0] s,
                                          input logic l, input logic a, input logic a32,
                                          output int lat);
        int          amt;
        logic [31:0] v32;
        logic [31:0] r32;
        amt = a32 ? int'(s[4:0]) : int'(s[5:0]);
        lat = (amt + STEP - 1) / STEP + 1;
        if (a32) begin
            v32 = v[31:0];
            r32 = l ? v32 << amt : a ? 32'($signed(v32) >>> amt) : v32 >> amt;
            return {32'b0, r32};
        end
        return l ? v << amt : a ? 64'($signed(v) >>> amt) : v >> amt;
    endfunction

    task automatic run_op(input string name, input logic [63:0] v, input logic [63:0] s,
                          input logic l, input logic a, input logic a32,
                          input logic [63:0] exp, input int exp_lat);
        int n;
        @(negedge clk);
        value = v; shift = s; left = l; arith = a; alu32 = a32; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        value = {$urandom, $urandom}; shift = {$urandom, $urandom};
        left = ~l; arith = ~a; alu32 = ~a32;
        check({name, " busy"}, 64'(busy), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 40);
        check({name, " lat"}, 64'(n), 64'(exp_lat));
        check({name, " out"}, out, exp);
        @(negedge clk);
        check({name, " ack1"}, 64'(ack), 64'd0);
        check({name, " idle"}, 64'(busy), 64'd0);
        check({name, " hold"}, out, exp);
    endtask

    initial begin
        int          lat;
        int          acks;
        int          first;
        int          second;
        logic [63:0] e;
        logic [63:0] v;
        logic [63:0] s;
        logic        l;
        logic        a;
        logic        a32;

        tbl[0] = '{64'h1000, 64'd1, 1'b0, 1'b0, 1'b0, 64'h800, 2};
        tbl[1] = '{64'h8000000000000080, 64'd4, 1'b0, 1'b1, 1'b0, 64'hF800000000000008, 2};
        tbl[2] = '{64'h8000000000000000, 64'd60, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 16};
        tbl[3] = '{64'd1, 64'd67, 1'b1, 1'b0, 1'b0, 64'h8, 2};
        tbl[4] = '{64'h123456789ABCDEF0, 64'd0, 1'b1, 1'b0, 1'b0, 64'h123456789ABCDEF0, 1};
        tbl[5] = '{64'hFFFFFFFF80000000, 64'd36, 1'b0, 1'b1, 1'b1, 64'h00000000F8000000, 2};
        tbl[6] = '{64'hFFFFFFFF80000000, 64'd36, 1'b0, 1'b0, 1'b1, 64'h0000000008000000, 2};
        tbl[7] = '{64'd1, 64'd63, 1'b1, 1'b0, 1'b0, 64'h8000000000000000, 17};
        tbl[8] = '{64'hFFFFFFFF0000000F, 64'd28, 1'b1, 1'b0, 1'b1, 64'h00000000F0000000, 8};
        tbl[9] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFC1, 1'b0, 1'b0, 1'b0, 64'h7FFFFFFFFFFFFFFF, 2};

        #3;
        check("reset out", out, 64'd0);
        check("reset ack", 64'(ack), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].a, tbl[i].a32,
                   tbl[i].exp, tbl[i].lat);

        for (int i = 0; i < 60; i++) begin
            v   = {$urandom, $urandom};
            s   = {$urandom, $urandom};
            l   = 1'($urandom_range(0, 1));
            a   = 1'($urandom_range(0, 1));
            a32 = 1'($urandom_range(0, 1));
            e   = model(v, s, l, a, a32, lat);
            run_op($sformatf("rnd%0d", i), v, s, l, a, a32, e, lat);
        end

        // a strobe while busy must be dropped
        @(negedge clk);
        value = 64'h8000000000000000; shift = 64'd60; left = 1'b0; arith = 1'b1; alu32 = 1'b0; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (3) @(negedge clk);
        value = 64'd1; shift = 64'd0; left = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        acks = 0;
        e = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                e = out;
            end
        end
        check("busy stb acks", 64'(acks), 64'd1);
        check("busy stb out", e, 64'hFFFFFFFFFFFFFFF8);

        // stb held high: one request per idle visit, three cycles apart for amt=0
        @(negedge clk);
        value = 64'd5; shift = 64'd0; left = 1'b1; stb = 1'b1;
        acks = 0; first = -1; second = -1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        stb = 1'b0;
        check("held stb acks", 64'(acks), 64'd3);
        check("held stb gap", 64'(second - first), 64'd3);
        check("held stb out", out, 64'd5);
        repeat (3) @(negedge clk);

        // reset mid-run aborts without an ack
        value = 64'h8000000000000000; shift = 64'd60; left = 1'b0; arith = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #0.5;
        check("rst out", out, 64'd0);
        check("rst ack", 64'(ack), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("rst no ack", 64'(acks), 64'd0);
        run_op("post rst", 64'h1000, 64'd1, 1'b0, 1'b0, 1'b0, 64'h800, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
